// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and counter sizing for serial_adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter width; a 1-bit counter is still needed when WIDTH=1
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  // Sum and carry of three input bits
  always_comb begin
    o_s = i_a ^ i_b ^ i_c;
    o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
  end

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder; optional subtract mode via SERIAL_ADDER_SUB_EN
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_done;

  logic             w_fa_s;
  logic             w_fa_co;
  logic [WIDTH-1:0] w_sum_next;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;
  logic             w_last;

  full_adder u_fa (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_carry),
    .o_s (w_fa_s),
    .o_c (w_fa_co)
  );

  // Operand B and initial carry as loaded; subtract mode adds the ones' complement plus one
  always_comb begin
    w_b_load = b;
    w_c_load = c_in;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      w_b_load = ~b;
      w_c_load = 1'b1;
    end
`endif
  end

  // Partial sum after this bit: new bit enters at the MSB, earlier bits move toward the LSB
  always_comb begin
    w_sum_next = r_sum_sh >> 1;
    w_sum_next[WIDTH-1] = w_fa_s;
  end

  assign w_last = (r_state == SHIFT) && (r_count == LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode; start is only looked at while idle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SHIFT;
      SHIFT:   if (r_count == LAST) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ready = (r_state == IDLE);
  end

  // Datapath: capture operands, shift one bit per cycle, publish result on the final bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_count  <= '0;
      r_sum    <= '0;
      r_c_out  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= w_b_load;
            r_carry  <= w_c_load;
            r_sum_sh <= '0;
            r_count  <= '0;
          end
        end
        SHIFT: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_next;
          r_carry  <= w_fa_co;
          r_count  <= r_count + 1'b1;
          if (r_count == LAST) begin
            r_sum   <= w_sum_next;
            r_c_out <= w_fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign done  = r_done;
  assign sum   = r_sum;
  assign c_out = r_c_out;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         c_out;
    int           cyc;
  } exp_t;

  exp_t q[$];

  bit           m_idle = 1'b1;
  int           m_acc = 0;
  logic [W-1:0] held_sum = '0;
  logic         held_c = 1'b0;
  logic         prev_done = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: plain integer arithmetic on the operands
  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic s, int dc);
    exp_t e;
    int unsigned r;
    int xi, yi;
    xi = int'(x);
    yi = int'(y);
    if (s) begin
      e.sum   = W'(xi - yi);
      e.c_out = (xi >= yi);
    end else begin
      r       = x + y + ci;
      e.sum   = r[W-1:0];
      e.c_out = r[W];
    end
    e.cyc = dc;
    return e;
  endfunction

  // Acceptance tracker: decides when an operation is taken and queues its expected result
  always @(negedge clk) begin
    if (rst) begin
      m_idle = 1'b1;
      q.delete();
    end else begin
      if (!m_idle && cyc == m_acc + W + 1) m_idle = 1'b1;
      check("ready", ready, m_idle);
      if (m_idle && start) begin
        m_acc = cyc + 1;
        q.push_back(model(a, b, c_in, sub, m_acc + W));
        m_idle = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever done is presented
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_sum  = '0;
      held_c    = 1'b0;
      prev_done = 1'b0;
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_c_out", c_out, 0);
    end else begin
      if (done) begin
        check("done_one_cycle", prev_done, 0);
        if (q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = q.pop_front();
          check("sum", sum, e.sum);
          check("c_out", c_out, e.c_out);
          check("done_cycle", cyc, e.cyc);
          held_sum = e.sum;
          held_c   = e.c_out;
        end
      end else begin
        check("sum_hold", sum, held_sum);
        check("c_out_hold", c_out, held_c);
      end
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    if (!ready) check("ready_timeout", ready, 1);
  endtask

  task automatic issue(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic s);
    wait_ready();
    a = x;
    b = y;
    c_in = ci;
    sub = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    c_in = 1'($urandom);
  endtask

  initial begin
    logic s_rand;
    int n;
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("init_ready", ready, 1);
    check("init_done", done, 0);
    check("init_sum", sum, 0);
    check("init_c_out", c_out, 0);

    issue(8'h00, 8'h00, 1'b0, 1'b0);
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    issue(8'h5A, 8'hA5, 1'b1, 1'b0);
    issue(8'h3C, 8'h42, 1'b0, 1'b0);

    // start held high with operands changing every cycle
    wait_ready();
    a = 8'h11;
    b = 8'h22;
    c_in = 1'b0;
    start = 1'b1;
    repeat (3 * (W + 2) - 1) begin
      tick();
      a = W'($urandom);
      b = W'($urandom);
      c_in = 1'($urandom);
    end
    start = 1'b0;

    // reset in the third shift cycle
    wait_ready();
    a = 8'h12;
    b = 8'h34;
    c_in = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_c_out", c_out, 0);
    tick();
    rst = 1'b0;
    repeat (W + 4) tick();
    issue(8'h12, 8'h34, 1'b0, 1'b0);

    repeat (40) begin
      s_rand = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      s_rand = 1'($urandom);
`endif
      issue(W'($urandom), W'($urandom), 1'($urandom), s_rand);
    end
    issue(8'hFF, 8'hFF, 1'b1, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    issue(8'h10, 8'h01, 1'b0, 1'b1);
    issue(8'h01, 8'h02, 1'b1, 1'b1);
    issue(8'h7B, 8'h3C, 1'b0, 1'b0);
`endif

    n = 0;
    while ((q.size() != 0 || !m_idle) && n < 100) begin
      tick();
      n++;
    end
    check("drain", q.size(), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
